// File: rtl/census_pkg.sv
// Shared types and constants for the census window sequencer: FSM states, beat count
// and the 3x3 neighbourhood offset table.
package census_pkg;

    localparam int unsigned IMG_W_DEF = 8;
    localparam int unsigned IMG_H_DEF = 8;
    localparam int unsigned BEATS     = 9;
    localparam logic [3:0]  K_LAST    = 4'(BEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // Slot 0 is the centre; slots 1..8 walk the ring in census bit order (bit 7 first).
    function automatic logic signed [1:0] offs_dx(input logic [3:0] k);
        case (k)
            4'd1, 4'd4, 4'd6: offs_dx = -2'sd1;
            4'd3, 4'd5, 4'd8: offs_dx = 2'sd1;
            default:          offs_dx = 2'sd0;
        endcase
    endfunction

    function automatic logic signed [1:0] offs_dy(input logic [3:0] k);
        case (k)
            4'd1, 4'd2, 4'd3: offs_dy = -2'sd1;
            4'd6, 4'd7, 4'd8: offs_dy = 2'sd1;
            default:          offs_dy = 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/census_window_addr.sv
// Combinational neighbour address generator for slot k around centre (x,y).
// CENSUS_FEEDER_REPLICATE_EN clamps out-of-image neighbours to the edge instead of flagging them.
module census_window_addr
    import census_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    localparam int unsigned XW = $clog2(IMG_W),
    localparam int unsigned YW = $clog2(IMG_H),
    localparam int unsigned AW = XW + YW
) (
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    input  logic [3:0]    i_k,
    output logic [AW-1:0] o_addr,
    output logic          o_oob
);

    localparam int unsigned XW1 = XW + 1;
    localparam int unsigned YW1 = YW + 1;

    logic signed [1:0] w_dx;
    logic signed [1:0] w_dy;
    logic [XW:0]       w_nx;
    logic [YW:0]       w_ny;
    logic [XW-1:0]     w_cx;
    logic [YW-1:0]     w_cy;

    assign w_dx = offs_dx(i_k);
    assign w_dy = offs_dy(i_k);

    // Results span -1..IMG_W, so the extra top bit is set exactly when the slot leaves the image.
    assign w_nx = {1'b0, i_x} + XW1'(w_dx);
    assign w_ny = {1'b0, i_y} + YW1'(w_dy);

`ifdef CENSUS_FEEDER_REPLICATE_EN
    assign w_cx  = w_nx[XW] ? (w_dx[1] ? '0 : '1) : w_nx[XW-1:0];
    assign w_cy  = w_ny[YW] ? (w_dy[1] ? '0 : '1) : w_ny[YW-1:0];
    assign o_oob = 1'b0;
`else
    assign w_cx  = w_nx[XW-1:0];
    assign w_cy  = w_ny[YW-1:0];
    assign o_oob = w_nx[XW] | w_ny[YW];
`endif

    assign o_addr = {w_cy, w_cx};

endmodule

// File: rtl/census_feeder.sv
// Sequences a 3x3 window from the image SRAM into the census unit as nine beats.
// CENSUS_FEEDER_REPLICATE_EN selects edge replication instead of zero padding.
module census_feeder
    import census_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    localparam int unsigned XW = $clog2(IMG_W),
    localparam int unsigned YW = $clog2(IMG_H),
    localparam int unsigned AW = XW + YW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_mem_ren,
    output logic [AW-1:0] o_mem_addr,
    input  logic [23:0]   i_mem_rdata,
    output logic [23:0]   o_data,
    output logic          o_center,
    output logic          o_padding
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [3:0]    r_k;
    logic [3:0]    w_k_nxt;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [AW-1:0] r_addr;
    logic          r_beat_valid;
    logic          r_beat_pad;
    logic          r_beat_center;
    logic          w_accept;
    logic          w_issue;
    logic [AW-1:0] w_addr;
    logic          w_oob;

    census_window_addr #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_window_addr (
        .i_x    (r_x),
        .i_y    (r_y),
        .i_k    (r_k),
        .o_addr (w_addr),
        .o_oob  (w_oob)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_accept    = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StIssue;
                    w_k_nxt     = '0;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StIssue: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = StDrain;
                end else begin
                    w_k_nxt = r_k + 4'd1;
                end
            end
            StDrain: w_state_nxt = StDone;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_k           <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_addr        <= '0;
            r_beat_valid  <= 1'b0;
            r_beat_pad    <= 1'b0;
            r_beat_center <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (w_accept) begin
                r_x <= i_x;
                r_y <= i_y;
            end
            r_addr        <= o_mem_addr;
            r_beat_valid  <= w_issue;
            r_beat_pad    <= w_issue & w_oob;
            r_beat_center <= w_issue & (r_k == 4'd0);
        end
    end

    assign w_issue    = (r_state == StIssue);
    assign o_busy     = (r_state == StIssue) || (r_state == StDrain);
    assign o_done     = (r_state == StDone);
    assign o_mem_ren  = w_issue & ~w_oob;
    // Padded slots leave the SRAM address bus where it was.
    assign o_mem_addr = o_mem_ren ? w_addr : r_addr;

    assign o_center  = r_beat_valid & r_beat_center;
    assign o_padding = r_beat_valid & r_beat_pad;
    assign o_data    = (r_beat_valid & ~r_beat_pad) ? i_mem_rdata : 24'd0;

endmodule

// File: tb/tb_census_feeder.sv
// Randomised scoreboard bench for census_feeder with an SRAM model (mem[a]={a,a,a})
// and a census unit model; honours CENSUS_FEEDER_REPLICATE_EN.
module tb_census_feeder;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    x = '0;
    logic [2:0]    y = '0;
    logic          o_busy, o_done, o_mem_ren, o_center, o_padding;
    logic [AW-1:0] o_mem_addr;
    logic [23:0]   mem_rdata = '0;
    logic [23:0]   o_data;

    census_feeder #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_x         (x),
        .i_y         (y),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_mem_ren   (o_mem_ren),
        .o_mem_addr  (o_mem_addr),
        .i_mem_rdata (mem_rdata),
        .o_data      (o_data),
        .o_center    (o_center),
        .o_padding   (o_padding)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: one-cycle latency, garbage on the bus when not read.
    always @(posedge clk) begin
        if (o_mem_ren) mem_rdata <= {3{2'b00, o_mem_addr}};
        else           mem_rdata <= 24'($urandom);
    end

    // Census unit: latch centre, shift in "neighbour > centre" per channel every cycle.
    logic [23:0] cen = '0;
    logic [23:0] census = '0;
    always @(posedge clk) begin
        if (o_center) cen <= o_data;
        for (int c = 0; c < 3; c++) begin
            census[c*8 +: 8] <= {census[c*8 +: 7],
                                 (!o_padding && (o_data[c*8 +: 8] > cen[c*8 +: 8]))};
        end
    end

    typedef struct packed {
        int               s;
        logic [8:0]       ren;
        logic [8:0][5:0]  addr;
        logic [8:0]       pad;
        logic [8:0][23:0] data;
        logic [23:0]      result;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   DXT[9] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
    int   DYT[9] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic exp_t build(input int xc, input int yc, input int s);
        exp_t e;
        int   v[9];
        e = '0;
        e.s = s;
        for (int k = 0; k < 9; k++) begin
            int nx, ny;
            bit oob;
            nx = xc + DXT[k];
            ny = yc + DYT[k];
            oob = (nx < 0) || (nx >= W) || (ny < 0) || (ny >= H);
`ifdef CENSUS_FEEDER_REPLICATE_EN
            nx = (nx < 0) ? 0 : (nx >= W) ? W - 1 : nx;
            ny = (ny < 0) ? 0 : (ny >= H) ? H - 1 : ny;
            oob = 1'b0;
`endif
            v[k]      = ny * W + nx;
            e.ren[k]  = !oob;
            e.pad[k]  = oob;
            e.addr[k] = oob ? 6'd0 : 6'(v[k]);
            e.data[k] = oob ? 24'd0 : {3{8'(v[k])}};
        end
        for (int k = 1; k < 9; k++) begin
            if (!e.pad[k] && v[k] > v[0]) e.result = e.result | (24'h010101 << (8 - k));
        end
        return e;
    endfunction

    // Monitor: checks every cycle against the transaction at the head of the scoreboard.
    int last_addr = 0;
    always @(negedge clk) begin
        exp_t e;
        int   rel;
        if (!rst_n) begin
            last_addr = 0;
        end else begin
            rel = -1;
            e   = '0;
            if (sb.size() > 0) begin
                e   = sb[0];
                rel = cyc - e.s;
            end
            if (rel >= 1 && rel <= 9) begin
                chk("mem_ren", 32'(o_mem_ren), 32'(e.ren[rel-1]));
                if (e.ren[rel-1]) last_addr = int'(e.addr[rel-1]);
                chk("mem_addr", 32'(o_mem_addr), 32'(last_addr));
            end else begin
                chk("mem_ren_idle", 32'(o_mem_ren), 32'd0);
            end
            if (rel >= 2 && rel <= 10) begin
                chk("center", 32'(o_center), 32'(rel == 2));
                chk("padding", 32'(o_padding), 32'(e.pad[rel-2]));
                chk("data", 32'(o_data), 32'(e.data[rel-2]));
            end else begin
                chk("beat_idle", {o_center, o_padding, o_data}, 32'd0);
            end
            chk("busy", 32'(o_busy), 32'(rel >= 1 && rel <= 10));
            chk("done", 32'(o_done), 32'(rel == 11));
            if (rel == 11) begin
                chk("census_result", 32'(census), 32'(e.result));
                void'(sb.pop_front());
            end
        end
    end

    task automatic do_start(input int xc, input int yc);
        int guard = 0;
        while (o_busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_before_start", 32'(o_busy), 32'd0);
        start = 1'b1;
        x = 3'(xc);
        y = 3'(yc);
        sb.push_back(build(xc, yc, cyc));
        @(negedge clk);
        start = 1'b0;
        x = 3'($urandom);
        y = 3'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {27'd0, o_busy, o_done, o_mem_ren, o_center, o_padding}, 32'd0);
        chk({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
        chk({tag, "_data"}, 32'(o_data), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_start(3, 3);
        repeat (11) @(negedge clk);
        do_start(0, 0);
        repeat (11) @(negedge clk);
        do_start(7, 7);
        repeat (11) @(negedge clk);

        // Start while busy must be ignored.
        do_start(2, 5);
        repeat (3) @(negedge clk);
        start = 1'b1;
        x = 3'd6;
        y = 3'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);

        // Start presented in DONE is accepted immediately.
        do_start(1, 6);
        repeat (10) @(negedge clk);
        do_start(6, 0);
        repeat (11) @(negedge clk);

        // Asynchronous reset mid-window.
        do_start(3, 3);
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        sb.delete();
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        do_start(3, 3);
        repeat (11) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            int n;
            do_start(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)));
            n = int'($urandom_range(10, 13));
            for (int j = 0; j < n; j++) begin
                start = o_busy && ($urandom_range(0, 3) == 0);
                x = 3'($urandom);
                y = 3'($urandom);
                @(negedge clk);
            end
            start = 1'b0;
        end
        repeat (14) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/census_feeder.md
# census_feeder

Window sequencer that drives the census-transform unit. On a start command with a centre coordinate, it fetches the 3x3 neighbourhood from the image SRAM and presents nine beats on the census input triple (data/center/padding): the centre first, then 8 neighbours in census bit order. Out-of-image neighbours are flagged as padding without issuing a read. It sits between the controller FSM, the image SRAM read port and the census unit, and pulses done when the census result register holds the finished 24-bit code.

## Interface
- IMG_W, 8, image width in pixels (power of two, ≥2)
- IMG_H, 8, image height in pixels (power of two, ≥2)
- Derived localparams: XW=log2(IMG_W), YW=log2(IMG_H), AW=XW+YW.

- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse, accepted only while o_busy=0
- i_x  in  XW  centre column, sampled on accepted start
- i_y  in  YW  centre row, sampled on accepted start
- o_busy  out  1  high in ISSUE/DRAIN
- o_done  out  1  one-cycle pulse: census result valid this cycle
- o_mem_ren  out  1  SRAM read enable
- o_mem_addr  out  AW  SRAM address = y*IMG_W + x
- i_mem_rdata  in  24  SRAM data {R,G,B}, valid 1 cycle after ren
- o_data  out  24  to census i_data
- o_center  out  1  to census i_center
- o_padding  out  1  to census i_padding

## Operation
- FSM: IDLE -> ISSUE (9 cycles, index k=0..8) -> DRAIN (1 cycle) -> DONE (1 cycle) -> IDLE. A start in DONE goes directly to ISSUE (k=0).
- Offset table by k as (dx,dy): 0:(0,0) centre; 1:(-1,-1) 2:(0,-1) 3:(+1,-1) 4:(-1,0) 5:(+1,0) 6:(-1,+1) 7:(0,+1) 8:(+1,+1). Neighbour k=1 lands in census bit 7, k=8 in bit 0.
- Coordinates are computed signed, one bit wider than XW/YW. The slot is out of image if x+dx∉[0,IMG_W-1] or y+dy∉[0,IMG_H-1]. Centre is always in image.
- In-image slot: o_mem_ren=1, o_mem_addr=address. Out-of-image slot: o_mem_ren=0, o_mem_addr holds its previous value, pad flag set.
- Beat stage (registered 1 cycle behind issue): beat_valid, pad, center flags. o_center=beat_valid&(k==0). o_padding=beat_valid&pad. o_data=(beat_valid&~pad)?i_mem_rdata:0.
- i_start while o_busy=1 is ignored. i_x/i_y are ignored except on an accepted start.

## Timing
- Start sampled at edge T. Issue cycles T+1..T+9. Beats on the census side T+2..T+10, with o_center=1 at T+2. o_done=1 at T+11, which is exactly when the census output holds the 8 neighbour comparisons. Start-to-done latency is 11 cycles; back-to-back period is 11 cycles.
- o_busy=1 for T+1..T+10.
- Reset (async, any state) forces IDLE. o_busy, o_done, o_mem_ren, o_center, o_padding and o_mem_addr are 0, and o_data is 0 (beat_valid=0). This holds regardless of i_mem_rdata. No partial result is signalled after reset release.
- Outside T+2..T+10, o_center=o_padding=0 and o_data=0. The census unit keeps shifting, but only beats T+3..T+10 occupy bits at done.

## Configuration
- CENSUS_FEEDER_REPLICATE_EN defined: out-of-image neighbours are clamped to the nearest edge pixel. A real read is issued (o_mem_ren=1) with o_padding=0, giving edge replication.
- CENSUS_FEEDER_REPLICATE_EN undefined (default): zero padding as described above.
- Timing is identical in both modes.

## Structure
- census_pkg: state enum (IDLE/ISSUE/DRAIN/DONE), 9-entry dx/dy offset table, default IMG_W/IMG_H, beat count constant 9.
- Sub-module census_window_addr: purely combinational. It takes (x,y,k) and returns (addr, oob), with the clamp option inside.
- census_feeder holds the FSM, k counter, latched centre and beat-stage registers.

## Test plan
Memory model: mem[a]={a,a,a}, 8x8 image, 1-cycle read latency, census unit attached.
- Start (3,3): reads 27,18,19,20,26,28,34,35,36 at T+1..T+9; o_done at T+11 with census o_data=0x0F0F0F; o_padding never high.
- Start (0,0), zero padding: o_mem_ren high exactly 4 cycles (addresses 0,1,8,9); o_padding high on beats k=1,2,3,4,6; census result 0x0B0B0B.
- Start (7,7): reads 63,54,55,62 only; padding on k=3,5,6,7,8; result 0x000000.
- With CENSUS_FEEDER_REPLICATE_EN, start (0,0): 9 reads (0,0,1,0,1,8,8,9 after centre 0), o_padding never high, result 0x2F2F2F.
- Second start at T+5 is ignored (o_done still only at T+11). A start at T+11 (DONE) is accepted and yields o_done at T+22.
- Reset asserted at T+5: all outputs 0 immediately, no o_done afterwards. A fresh start (3,3) after release yields 0x0F0F0F 11 cycles later.
